// File: rtl/bist_scheduler.sv
// ---------------------------------------------------------------------------
// bist_scheduler
//   Top-level BIST sequencer. On one accepted start request it runs the
//   enabled circuits-under-test one at a time in ascending index order,
//   pulsing each per-CUT controller's bist_start and waiting for a fresh
//   rising edge on its bist_end. The per-CUT pass flags are collected into
//   fail_map, and an aggregate pass/done is reported once every index has
//   been visited.
//
//   Optional feature macro: BIST_TIMEOUT_EN
//     defined   - a per-CUT watchdog abandons a CUT after TIMEOUT cycles in
//                 WAIT, marking it failed and timed out.
//     undefined - WAIT has no limit and timeout_map is tied to zero.
// ---------------------------------------------------------------------------
module bist_scheduler #(
    parameter int NUM_CUT = 4,
    parameter int IDX_W   = $clog2(NUM_CUT + 1),
    parameter int TIMEOUT = 1023
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [NUM_CUT-1:0] cut_enable,
    input  logic [NUM_CUT-1:0] cut_bist_end,
    input  logic [NUM_CUT-1:0] cut_pass,
    output logic [NUM_CUT-1:0] cut_bist_start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_CUT-1:0] fail_map,
    output logic [IDX_W-1:0]   cur_cut,
    output logic [NUM_CUT-1:0] timeout_map
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_RECORD = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               start_q;
    logic               start_edge;
    logic [NUM_CUT-1:0] mask_q, mask_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               end_q, end_d;
    logic [NUM_CUT-1:0] cut_bist_start_q, cut_bist_start_d;
    logic [NUM_CUT-1:0] fail_map_q, fail_map_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    // One-hot decode of the current index; all-zero once idx reaches NUM_CUT,
    // so the per-CUT selects below never index out of range.
    logic [NUM_CUT-1:0] idx_hit;
    logic               idx_at_end;
    logic               sel_en;
    logic               sel_end;
    logic               sel_pass;
    logic               end_rise;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CUT; gi++) begin : g_idx_dec
            assign idx_hit[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    assign idx_at_end = (idx_q == IDX_W'(NUM_CUT));
    assign sel_en     = |(mask_q & idx_hit);
    assign sel_end    = |(cut_bist_end & idx_hit);
    assign sel_pass   = |(cut_pass & idx_hit);

    // A completion is only a fresh rising edge; a bist_end still high from an
    // earlier run is captured into end_q at ISSUE and must drop first.
    assign end_rise   = sel_end & ~end_q;
    assign start_edge = start & ~start_q;

`ifdef BIST_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [NUM_CUT-1:0] timeout_map_q, timeout_map_d;
    logic               timer_exp;

    assign timer_exp   = (timer_q == TMR_W'(TIMEOUT - 1));
    assign timeout_map = timeout_map_q;
`else
    logic timer_exp;

    assign timer_exp   = 1'b0;
    assign timeout_map = '0;
`endif

    // Next-state and next-output logic for the scheduler FSM.
    always_comb begin
        state_d          = state_q;
        mask_d           = mask_q;
        idx_d            = idx_q;
        end_d            = end_q;
        cut_bist_start_d = '0;
        fail_map_d       = fail_map_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
`ifdef BIST_TIMEOUT_EN
        timer_d          = timer_q;
        timeout_map_d    = timeout_map_q;
`endif

        case (state_q)
            // IDLE and DONE accept a new request identically; DONE also
            // drops done/pass, which the common action handles.
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    mask_d     = cut_enable;
                    idx_d      = '0;
                    fail_map_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
`ifdef BIST_TIMEOUT_EN
                    timeout_map_d = '0;
`endif
                    state_d    = S_SELECT;
                end
            end

            // Walk the index; disabled CUTs cost one cycle each.
            S_SELECT: begin
                if (idx_at_end) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = ~|fail_map_q;
                    state_d = S_DONE;
                end else if (sel_en) begin
                    cut_bist_start_d = idx_hit;
                    state_d          = S_ISSUE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            // The start pulse is visible during this state only.
            S_ISSUE: begin
                end_d   = sel_end;
`ifdef BIST_TIMEOUT_EN
                timer_d = '0;
`endif
                state_d = S_WAIT;
            end

            // A real completion edge takes priority over the watchdog.
            S_WAIT: begin
                end_d   = sel_end;
`ifdef BIST_TIMEOUT_EN
                timer_d = timer_q + TMR_W'(1);
`endif
                if (end_rise) begin
                    fail_map_d = (fail_map_q & ~idx_hit)
                               | (idx_hit & {NUM_CUT{~sel_pass}});
                    state_d    = S_RECORD;
                end else if (timer_exp) begin
                    fail_map_d = fail_map_q | idx_hit;
`ifdef BIST_TIMEOUT_EN
                    timeout_map_d = timeout_map_q | idx_hit;
`endif
                    state_d    = S_RECORD;
                end
            end

            S_RECORD: begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_SELECT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, including the
    // start history so a start held through reset is seen as a new edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= S_IDLE;
            start_q          <= 1'b0;
            mask_q           <= '0;
            idx_q            <= '0;
            end_q            <= 1'b0;
            cut_bist_start_q <= '0;
            fail_map_q       <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            start_q          <= start;
            mask_q           <= mask_d;
            idx_q            <= idx_d;
            end_q            <= end_d;
            cut_bist_start_q <= cut_bist_start_d;
            fail_map_q       <= fail_map_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
        end
    end

`ifdef BIST_TIMEOUT_EN
    // Watchdog counter and timeout record.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q       <= '0;
            timeout_map_q <= '0;
        end else begin
            timer_q       <= timer_d;
            timeout_map_q <= timeout_map_d;
        end
    end
`endif

    assign cut_bist_start = cut_bist_start_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_map       = fail_map_q;
    assign cur_cut        = idx_q;

endmodule

// File: tb/tb_bist_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bist_scheduler
//   Directed bench for bist_scheduler (NUM_CUT=4, TIMEOUT=16). Behavioural
//   per-CUT controllers drop bist_end two cycles after their start pulse and
//   raise it (with a configured pass flag) a configured number of cycles
//   later; latency 0 means the CUT never finishes. The timeout scenario only
//   runs when BIST_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_bist_scheduler;

    localparam int NUM_CUT = 4;
    localparam int IDX_W   = 3;
    localparam int TIMEOUT = 16;

    logic               clock;
    logic               reset;
    logic               start;
    logic [NUM_CUT-1:0] cut_enable;
    logic [NUM_CUT-1:0] cut_bist_end;
    logic [NUM_CUT-1:0] cut_pass;
    logic [NUM_CUT-1:0] cut_bist_start;
    logic               busy;
    logic               done;
    logic               pass;
    logic [NUM_CUT-1:0] fail_map;
    logic [IDX_W-1:0]   cur_cut;
    logic [NUM_CUT-1:0] timeout_map;

    int checks   = 0;
    int failures = 0;

    int                 lat_cfg [NUM_CUT];
    logic [NUM_CUT-1:0] pass_cfg;

    int   running   [NUM_CUT];
    int   elapsed   [NUM_CUT];
    int   pulse_cnt [NUM_CUT];
    int   pulse_base[NUM_CUT];
    int   pulse_log [$];
    int   log_base;
    int   multi_cnt = 0;
    int   cyc;

    bist_scheduler #(
        .NUM_CUT(NUM_CUT),
        .IDX_W  (IDX_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .cut_enable    (cut_enable),
        .cut_bist_end  (cut_bist_end),
        .cut_pass      (cut_pass),
        .cut_bist_start(cut_bist_start),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail_map      (fail_map),
        .cur_cut       (cur_cut),
        .timeout_map   (timeout_map)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Per-CUT controller models plus pulse monitor, updated 1 time unit
    // after each rising edge.
    initial begin
        cut_bist_end = '0;
        cut_pass     = '0;
        for (int i = 0; i < NUM_CUT; i++) begin
            running[i]   = 0;
            elapsed[i]   = 0;
            pulse_cnt[i] = 0;
        end
    end

    always @(posedge clock) begin
        #1;
        if ($countones(cut_bist_start) > 1) multi_cnt++;
        for (int i = 0; i < NUM_CUT; i++) begin
            if (cut_bist_start[i]) begin
                pulse_cnt[i]++;
                pulse_log.push_back(i);
            end
            if (reset) begin
                cut_bist_end[i] = 1'b0;
                cut_pass[i]     = 1'b0;
                running[i]      = 0;
                elapsed[i]      = 0;
            end else if (cut_bist_start[i]) begin
                running[i] = 1;
                elapsed[i] = 0;
            end else if (running[i] != 0) begin
                elapsed[i]++;
                if (elapsed[i] == 2) cut_bist_end[i] = 1'b0;
                if (lat_cfg[i] != 0 && elapsed[i] == lat_cfg[i]) begin
                    cut_bist_end[i] = 1'b1;
                    cut_pass[i]     = pass_cfg[i];
                    running[i]      = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < NUM_CUT; i++) pulse_base[i] = pulse_cnt[i];
        log_base = pulse_log.size();
    endtask

    task automatic chk_pulses(input string tag, input logic [NUM_CUT-1:0] exp_mask);
        for (int i = 0; i < NUM_CUT; i++)
            chk($sformatf("%s_pulses%0d", tag, i),
                32'(pulse_cnt[i] - pulse_base[i]), {31'd0, exp_mask[i]});
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        cut_enable = '0;
        pass_cfg   = 4'b1111;
        for (int i = 0; i < NUM_CUT; i++) lat_cfg[i] = 20;
        log_base = 0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_pass",   {31'd0, pass}, 32'd0);
        chk("rst_fail",   {28'd0, fail_map}, 32'd0);
        chk("rst_cur",    {29'd0, cur_cut}, 32'd0);
        chk("rst_start",  {28'd0, cut_bist_start}, 32'd0);
        chk("rst_tmo",    {28'd0, timeout_map}, 32'd0);
        reset = 1'b0;
        tick();

        // T1: all four CUTs, all pass
        cut_enable = 4'b1111;
        snap();
        start = 1'b1;
        tick();
        chk("t1_busy_acc", {31'd0, busy}, 32'd1);
        wait_done("t1", 300, cyc);
        chk("t1_cycles", cyc, 93);
        chk_pulses("t1", 4'b1111);
        chk("t1_logsz", pulse_log.size() - log_base, 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t1_order%0d", k), pulse_log[log_base + k], k);
        chk("t1_pass", {31'd0, pass}, 32'd1);
        chk("t1_fail", {28'd0, fail_map}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_cur",  {29'd0, cur_cut}, 32'd4);
        start = 1'b0;
        tick();

        // T2: CUTs 1 and 3 only, CUT3 fails; enable changes after acceptance
        cut_enable = 4'b1010;
        pass_cfg   = 4'b0111;
        snap();
        start = 1'b1;
        tick();
        chk("t2_busy_acc", {31'd0, busy}, 32'd1);
        chk("t2_done_clr", {31'd0, done}, 32'd0);
        chk("t2_pass_clr", {31'd0, pass}, 32'd0);
        cut_enable = 4'b1111;
        wait_done("t2", 300, cyc);
        chk("t2_cycles", cyc, 49);
        chk_pulses("t2", 4'b1010);
        chk("t2_order0", pulse_log[log_base], 1);
        chk("t2_order1", pulse_log[log_base + 1], 3);
        chk("t2_fail", {28'd0, fail_map}, 32'h8);
        chk("t2_pass", {31'd0, pass}, 32'd0);
        chk("t2_busy", {31'd0, busy}, 32'd0);
        chk("t2_tmo",  {28'd0, timeout_map}, 32'd0);
        start = 1'b0;
        tick();

        // T3: empty mask, started from DONE with a non-zero fail_map
        cut_enable = 4'b0000;
        snap();
        start = 1'b1;
        tick();
        chk("t3_fail_clr", {28'd0, fail_map}, 32'd0);
        chk("t3_done_clr", {31'd0, done}, 32'd0);
        chk("t3_busy_acc", {31'd0, busy}, 32'd1);
        wait_done("t3", 100, cyc);
        chk("t3_cycles", cyc, 5);
        chk_pulses("t3", 4'b0000);
        chk("t3_pass", {31'd0, pass}, 32'd1);
        chk("t3_fail", {28'd0, fail_map}, 32'd0);
        start = 1'b0;
        tick();

        // T5: ignored start re-toggle, then reset while waiting on CUT1
        cut_enable = 4'b1111;
        pass_cfg   = 4'b1111;
        snap();
        start = 1'b1;
        tick();
        repeat (10) tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("t5_busy_ign",  {31'd0, busy}, 32'd1);
        chk("t5_cur_ign",   {29'd0, cur_cut}, 32'd0);
        chk_pulses("t5_ign", 4'b0001);
        repeat (17) tick();
        chk("t5_cur_wait1", {29'd0, cur_cut}, 32'd1);
        chk_pulses("t5_pre", 4'b0011);
        reset = 1'b1;
        tick();
        chk("t5_rst_busy",  {31'd0, busy}, 32'd0);
        chk("t5_rst_done",  {31'd0, done}, 32'd0);
        chk("t5_rst_pass",  {31'd0, pass}, 32'd0);
        chk("t5_rst_fail",  {28'd0, fail_map}, 32'd0);
        chk("t5_rst_cur",   {29'd0, cur_cut}, 32'd0);
        chk("t5_rst_start", {28'd0, cut_bist_start}, 32'd0);
        tick();
        chk("t5_rst_start2", {28'd0, cut_bist_start}, 32'd0);
        snap();
        reset = 1'b0;
        tick();
        chk("t5_held_acc", {31'd0, busy}, 32'd1);
        wait_done("t5", 300, cyc);
        chk("t5_cycles", cyc, 93);
        chk("t5_first", pulse_log[log_base], 0);
        chk_pulses("t5", 4'b1111);
        chk("t5_pass", {31'd0, pass}, 32'd1);
        start = 1'b0;
        tick();

        // T6: second run with every bist_end still high; CUT0 now fails
        pass_cfg = 4'b1110;
        chk("t6_stale_end", {28'd0, cut_bist_end}, 32'hf);
        snap();
        start = 1'b1;
        tick();
        wait_done("t6", 300, cyc);
        chk("t6_cycles", cyc, 93);
        chk_pulses("t6", 4'b1111);
        chk("t6_fail", {28'd0, fail_map}, 32'h1);
        chk("t6_pass", {31'd0, pass}, 32'd0);
        chk("t6_tmo",  {28'd0, timeout_map}, 32'd0);
        start = 1'b0;
        tick();

`ifdef BIST_TIMEOUT_EN
        // T4: CUT2 never finishes and is abandoned by the watchdog
        cut_enable = 4'b0111;
        pass_cfg   = 4'b1111;
        lat_cfg[2] = 0;
        snap();
        start = 1'b1;
        tick();
        wait_done("t4", 300, cyc);
        chk("t4_cycles", cyc, 67);
        chk_pulses("t4", 4'b0111);
        chk("t4_tmo",  {28'd0, timeout_map}, 32'h4);
        chk("t4_fail", {28'd0, fail_map}, 32'h4);
        chk("t4_pass", {31'd0, pass}, 32'd0);
        start = 1'b0;
        tick();
`endif

        chk("onehot", multi_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
